// File: rtl/ibex_pkg.sv
// Shared types and constants for the EX-stage sequencer.
// Holds the multdiv configuration, the sequencer state encoding and the cycle-count limit.
package ibex_pkg;

    typedef enum integer {
        RV32MNone        = 0,
        RV32MSlow        = 1,
        RV32MFast        = 2,
        RV32MSingleCycle = 3
    } rv32m_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } ex_seq_state_e;

    localparam logic [5:0] ExSeqCntMax = 6'd63;
    localparam int unsigned ImdLanes = 2;
    localparam int unsigned ImdWidth = 34;

    // Saturating increment for the EXEC-cycle counter.
    function automatic logic [5:0] sat_inc(input logic [5:0] value);
        sat_inc = (value == ExSeqCntMax) ? value : value + 6'd1;
    endfunction

endpackage

// File: rtl/ibex_imd_val_regs.sv
// Two-lane intermediate-value storage for multicycle EX operations.
// Each lane has its own write enable; a clear wipes both lanes.
module ibex_imd_val_regs
    import ibex_pkg::*;
(
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               clr_i,
    input  logic [ImdLanes-1:0]                we_i,
    input  logic [ImdLanes-1:0][ImdWidth-1:0]  d_i,
    output logic [ImdLanes-1:0][ImdWidth-1:0]  q_o
);

    logic [ImdLanes-1:0][ImdWidth-1:0] q;

    // Lane storage: reset/clear take priority over per-lane writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q <= {(ImdLanes*ImdWidth){1'b0}};
        end else if (clr_i) begin
            q <= {(ImdLanes*ImdWidth){1'b0}};
        end else begin
            for (int k = 0; k < ImdLanes; k++) begin
                if (we_i[k]) begin
                    q[k] <= d_i[k];
                end
            end
        end
    end

    assign q_o = q;

endmodule

// File: rtl/ibex_ex_sequencer.sv
// EX-stage sequencer: tracks one in-flight instruction from issue through writeback,
// steering multdiv enables, intermediate-value storage and a writeback skid register.
module ibex_ex_sequencer
    import ibex_pkg::*;
#(
    parameter rv32m_e RV32M = RV32MFast
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               issue_valid_i,
    output logic                               issue_ready_o,
    input  logic                               issue_mult_i,
    input  logic                               issue_div_i,
    input  logic                               flush_i,
    input  logic                               ex_valid_i,
    input  logic [31:0]                        result_ex_i,
    input  logic [ImdLanes-1:0]                imd_val_we_i,
    input  logic [ImdLanes-1:0][ImdWidth-1:0]  imd_val_d_i,
    output logic [ImdLanes-1:0][ImdWidth-1:0]  imd_val_q_o,
    output logic                               instr_first_cycle_o,
    output logic                               mult_en_o,
    output logic                               div_en_o,
    output logic                               mult_sel_o,
    output logic                               div_sel_o,
    output logic                               multdiv_ready_id_o,
    output logic                               wb_valid_o,
    output logic [31:0]                        wb_result_o,
    input  logic                               wb_ready_i,
    output logic [5:0]                         exec_cycles_o
);

    ex_seq_state_e state_q, state_d;
    logic          mult_sel_q, div_sel_q, first_q;
    logic [5:0]    cnt_q;
    logic [31:0]   hold_result_q;
    logic          accept, capture, in_exec, in_hold, mult_req, div_req;
    logic [ImdLanes-1:0] imd_we;

    assign mult_req = (RV32M != RV32MNone) & issue_mult_i;
    assign div_req  = (RV32M != RV32MNone) & issue_div_i;
    assign in_exec  = (state_q == EXEC);
    assign in_hold  = (state_q == HOLD);
    assign accept   = (state_q == IDLE) & issue_valid_i & ~flush_i;
    assign capture  = in_exec & ex_valid_i & ~wb_ready_i & ~flush_i;

    // Next-state selection; flush abandons the instruction from any state.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = accept ? EXEC : IDLE;
                EXEC: begin
                    if (ex_valid_i) begin
                        state_d = wb_ready_i ? IDLE : HOLD;
                    end else begin
                        state_d = EXEC;
                    end
                end
                HOLD:    state_d = wb_ready_i ? IDLE : HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, issue-time selects, cycle counter and writeback skid register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            mult_sel_q    <= 1'b0;
            div_sel_q     <= 1'b0;
            first_q       <= 1'b0;
            cnt_q         <= 6'd0;
            hold_result_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mult_sel_q <= mult_req;
                div_sel_q  <= div_req;
                first_q    <= 1'b1;
                cnt_q      <= 6'd0;
            end else begin
                first_q <= 1'b0;
                if (in_exec) begin
                    cnt_q <= sat_inc(cnt_q);
                end
            end
            if (capture) begin
                hold_result_q <= result_ex_i;
            end
        end
    end

    // Writeback path: direct result in EXEC, skid register in HOLD, zero otherwise.
    always_comb begin
        wb_valid_o  = 1'b0;
        wb_result_o = 32'd0;
        if (flush_i || rst_i) begin
            wb_valid_o  = 1'b0;
            wb_result_o = 32'd0;
        end else if (in_exec && ex_valid_i && wb_ready_i) begin
            wb_valid_o  = 1'b1;
            wb_result_o = result_ex_i;
        end else if (in_hold) begin
            wb_valid_o  = 1'b1;
            wb_result_o = hold_result_q;
        end else begin
            wb_valid_o  = 1'b0;
            wb_result_o = 32'd0;
        end
    end

    assign imd_we = (in_exec && !flush_i) ? imd_val_we_i : {ImdLanes{1'b0}};

    ibex_imd_val_regs u_imd_val_regs (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .we_i  (imd_we),
        .d_i   (imd_val_d_i),
        .q_o   (imd_val_q_o)
    );

    assign issue_ready_o       = (state_q == IDLE);
    assign instr_first_cycle_o = in_exec & first_q;
    assign mult_en_o           = in_exec & mult_sel_q;
    assign div_en_o            = in_exec & div_sel_q;
    assign mult_sel_o          = mult_sel_q;
    assign div_sel_o           = div_sel_q;
    assign multdiv_ready_id_o  = in_exec & wb_ready_i;
    assign exec_cycles_o       = cnt_q;

endmodule

// File: tb/tb_ibex_ex_sequencer.sv
// Directed bench for ibex_ex_sequencer: inputs change on the falling edge,
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_ibex_ex_sequencer;
    import ibex_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              issue_valid = 1'b0, issue_ready, issue_mult = 1'b0, issue_div = 1'b0;
    logic              flush = 1'b0, ex_valid = 1'b0, wb_ready = 1'b0;
    logic [31:0]       result_ex = 32'd0, wb_result;
    logic [1:0]        imd_we = 2'b00;
    logic [1:0][33:0]  imd_d = '0, imd_q;
    logic              instr_first, mult_en, div_en, mult_sel, div_sel, multdiv_ready, wb_valid;
    logic [5:0]        exec_cycles;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    ibex_ex_sequencer #(.RV32M(RV32MFast)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .issue_valid_i       (issue_valid),
        .issue_ready_o       (issue_ready),
        .issue_mult_i        (issue_mult),
        .issue_div_i         (issue_div),
        .flush_i             (flush),
        .ex_valid_i          (ex_valid),
        .result_ex_i         (result_ex),
        .imd_val_we_i        (imd_we),
        .imd_val_d_i         (imd_d),
        .imd_val_q_o         (imd_q),
        .instr_first_cycle_o (instr_first),
        .mult_en_o           (mult_en),
        .div_en_o            (div_en),
        .mult_sel_o          (mult_sel),
        .div_sel_o           (div_sel),
        .multdiv_ready_id_o  (multdiv_ready),
        .wb_valid_o          (wb_valid),
        .wb_result_o         (wb_result),
        .wb_ready_i          (wb_ready),
        .exec_cycles_o       (exec_cycles)
    );

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Watchdog: report an expired wait if the sequence never completes.
    initial begin
        #100000;
        errors++;
        $error("FAIL timeout: sequence did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Directed stimulus and checks.
    initial begin
        // Reset
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        check("rst_ready", issue_ready, 1'b1);
        check("rst_wbv", wb_valid, 1'b0);
        check("rst_wbr", wb_result, 32'd0);
        check("rst_cnt", exec_cycles, 6'd0);
        check("rst_imd", imd_q, 68'd0);
        check("rst_first", instr_first, 1'b0);

        // Single-cycle ALU op
        @(negedge clk); issue_valid = 1'b1; #1;
        check("alu_ready", issue_ready, 1'b1);
        @(negedge clk); issue_valid = 1'b0; ex_valid = 1'b1; result_ex = 32'h12345678; wb_ready = 1'b1; #1;
        check("alu_first", instr_first, 1'b1);
        check("alu_wbv", wb_valid, 1'b1);
        check("alu_wbr", wb_result, 32'h12345678);
        check("alu_mdrdy", multdiv_ready, 1'b1);
        check("alu_mult_en", mult_en, 1'b0);
        @(negedge clk); ex_valid = 1'b0; result_ex = 32'd0; #1;
        check("alu_idle", issue_ready, 1'b1);
        check("alu_wbv_off", wb_valid, 1'b0);
        check("alu_wbr_off", wb_result, 32'd0);
        check("alu_cnt", exec_cycles, 6'd1);

        // Multicycle multiply with intermediate-value writes
        @(negedge clk); issue_valid = 1'b1; issue_mult = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            issue_valid = 1'b0; issue_mult = 1'b0;
            imd_we = (i == 0) ? 2'b11 : 2'b00;
            imd_d  = (i == 0) ? {34'h3_0000_0001, 34'h0_FFFF_FFFF} : '0;
            ex_valid = (i == 3);
            result_ex = 32'h0000_00AB;
            #1;
            check("mul_en", mult_en, 1'b1);
            check("mul_first", instr_first, (i == 0));
            if (i == 1) begin
                check("mul_imd1", imd_q[1], 34'h3_0000_0001);
                check("mul_imd0", imd_q[0], 34'h0_FFFF_FFFF);
            end
            if (i == 3) begin
                check("mul_wbv", wb_valid, 1'b1);
                check("mul_wbr", wb_result, 32'h0000_00AB);
            end
        end
        @(negedge clk); ex_valid = 1'b0; #1;
        check("mul_en_off", mult_en, 1'b0);
        check("mul_cnt", exec_cycles, 6'd4);
        check("mul_sel", mult_sel, 1'b1);
        check("mul_imd_hold", imd_q[1], 34'h3_0000_0001);

        // Backpressure into HOLD
        @(negedge clk); issue_valid = 1'b1; issue_mult = 1'b1;
        @(negedge clk); issue_valid = 1'b0; issue_mult = 1'b0;
        ex_valid = 1'b1; wb_ready = 1'b0; result_ex = 32'hDEADBEEF; #1;
        check("bp_exec_wbv", wb_valid, 1'b0);
        check("bp_exec_mden", mult_en, 1'b1);
        @(negedge clk); ex_valid = 1'b0; result_ex = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_wbv", wb_valid, 1'b1);
            check("bp_wbr", wb_result, 32'hDEADBEEF);
            check("bp_mult_en", mult_en, 1'b0);
            check("bp_mdrdy", multdiv_ready, 1'b0);
            check("bp_ready", issue_ready, 1'b0);
            @(negedge clk);
        end
        wb_ready = 1'b1; #1;
        check("bp_drain_wbv", wb_valid, 1'b1);
        check("bp_drain_mdrdy", multdiv_ready, 1'b0);
        @(negedge clk); wb_ready = 1'b0; #1;
        check("bp_idle", issue_ready, 1'b1);
        check("bp_wbv_off", wb_valid, 1'b0);
        check("bp_cnt", exec_cycles, 6'd1);

        // Flush in EXEC
        @(negedge clk); issue_valid = 1'b1;
        @(negedge clk); issue_valid = 1'b0; flush = 1'b1; imd_we = 2'b01;
        imd_d = {34'h1_1111_1111, 34'h2_2222_2222}; ex_valid = 1'b1; wb_ready = 1'b1; #1;
        check("fl_wbv", wb_valid, 1'b0);
        check("fl_wbr", wb_result, 32'd0);
        @(negedge clk); flush = 1'b0; imd_we = 2'b00; ex_valid = 1'b0; wb_ready = 1'b0; #1;
        check("fl_idle", issue_ready, 1'b1);
        check("fl_imd", imd_q, 68'd0);

        // Issue together with flush in IDLE is refused
        @(negedge clk); issue_valid = 1'b1; issue_div = 1'b1; flush = 1'b1;
        @(negedge clk); issue_valid = 1'b0; issue_div = 1'b0; flush = 1'b0; #1;
        check("if_ready", issue_ready, 1'b1);
        check("if_div_sel", div_sel, 1'b0);
        check("if_div_en", div_en, 1'b0);

        // Issue during EXEC is ignored
        @(negedge clk); issue_valid = 1'b1; issue_div = 1'b1;
        @(negedge clk); issue_div = 1'b0; issue_mult = 1'b1; #1;
        check("ie_div_en", div_en, 1'b1);
        check("ie_first", instr_first, 1'b1);
        @(negedge clk); issue_valid = 1'b0; issue_mult = 1'b0; #1;
        check("ie_div_sel", div_sel, 1'b1);
        check("ie_mult_sel", mult_sel, 1'b0);
        check("ie_first2", instr_first, 1'b0);
        check("ie_cnt", exec_cycles, 6'd1);
        ex_valid = 1'b1; wb_ready = 1'b1;
        @(negedge clk); ex_valid = 1'b0; wb_ready = 1'b0; #1;
        check("ie_idle", issue_ready, 1'b1);
        check("ie_cnt2", exec_cycles, 6'd2);

        // Reset while in HOLD
        @(negedge clk); issue_valid = 1'b1; issue_mult = 1'b1;
        @(negedge clk); issue_valid = 1'b0; issue_mult = 1'b0; ex_valid = 1'b1;
        result_ex = 32'hCAFEF00D; imd_we = 2'b11; imd_d = {34'h0_0000_00AA, 34'h0_0000_0055};
        @(negedge clk); ex_valid = 1'b0; imd_we = 2'b00; #1;
        check("rh_hold_wbv", wb_valid, 1'b1);
        check("rh_hold_imd", imd_q[0], 34'h0_0000_0055);
        rst = 1'b1; wb_ready = 1'b1; #1;
        check("rh_rst_wbv", wb_valid, 1'b0);
        @(negedge clk); rst = 1'b0; wb_ready = 1'b0; #1;
        check("rh_ready", issue_ready, 1'b1);
        check("rh_wbv", wb_valid, 1'b0);
        check("rh_wbr", wb_result, 32'd0);
        check("rh_cnt", exec_cycles, 6'd0);
        check("rh_imd", imd_q, 68'd0);
        check("rh_mult_sel", mult_sel, 1'b0);
        check("rh_mult_en", mult_en, 1'b0);
        check("rh_first", instr_first, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
